// File: rtl/bram_arbiter.sv
// Zero-fill sequencer and round-robin two-requester arbiter in front of a single-port block RAM.
// Read data returns three cycles after acceptance, tagged back to the requester that issued it.
module bram_arbiter #(
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_req,
    output logic                      clear_done,
    input  logic                      a_valid,
    input  logic                      a_wr,
    input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
    input  logic [RAM_DATA_WIDTH-1:0] a_wdata,
    output logic                      a_ready,
    output logic                      a_rsp_valid,
    output logic [RAM_DATA_WIDTH-1:0] a_rsp_data,
    input  logic                      b_valid,
    input  logic                      b_wr,
    input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
    input  logic [RAM_DATA_WIDTH-1:0] b_wdata,
    output logic                      b_ready,
    output logic                      b_rsp_valid,
    output logic [RAM_DATA_WIDTH-1:0] b_rsp_data,
    output logic                      mem_wr,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [RAM_DATA_WIDTH-1:0] mem_wdata,
    input  logic [RAM_DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned DEPTH = 2 ** RAM_ADDR_WIDTH;
    localparam logic [RAM_ADDR_WIDTH:0] CNT_LAST = (RAM_ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {StClear = 1'b0, StServe = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                      rr_last_q, rr_last_d;  // 1: B was granted last
    logic                      clear_done_q;
    logic                      grant_a, grant_b;

    logic                      mem_wr_q, mem_wr_d;
    logic [RAM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [RAM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    // Tag pipeline {is_read, id} tracks the mem stage, then the RAM output stage.
    logic                      tag1_rd_q, tag1_rd_d, tag1_id_q, tag1_id_d;
    logic                      tag2_rd_q, tag2_id_q;

    logic                      a_rsp_valid_q, b_rsp_valid_q;
    logic [RAM_DATA_WIDTH-1:0] a_rsp_data_q, b_rsp_data_q;

    // Grants also wait for clear_done so ready never leads the status flag.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == StServe && clear_done_q && !clr_req) begin
            if (a_valid && b_valid) begin
                grant_a = rr_last_q;
                grant_b = !rr_last_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag1_rd_d   = 1'b0;
        tag1_id_d   = 1'b0;
        case (state_q)
            StClear: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = cnt_q[RAM_ADDR_WIDTH-1:0];
                mem_wdata_d = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = StServe;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StServe: begin
                if (clr_req) begin
                    state_d = StClear;
                end else if (grant_a) begin
                    mem_wr_d    = a_wr;
                    mem_addr_d  = a_addr;
                    mem_wdata_d = a_wdata;
                    tag1_rd_d   = !a_wr;
                    tag1_id_d   = 1'b0;
                    rr_last_d   = 1'b0;
                end else if (grant_b) begin
                    mem_wr_d    = b_wr;
                    mem_addr_d  = b_addr;
                    mem_wdata_d = b_wdata;
                    tag1_rd_d   = !b_wr;
                    tag1_id_d   = 1'b1;
                    rr_last_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StClear;
            cnt_q         <= '0;
            rr_last_q     <= 1'b1;
            clear_done_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tag1_rd_q     <= 1'b0;
            tag1_id_q     <= 1'b0;
            tag2_rd_q     <= 1'b0;
            tag2_id_q     <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rsp_data_q  <= '0;
            b_rsp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_last_q     <= rr_last_d;
            clear_done_q  <= (state_q == StServe);
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            tag1_rd_q     <= tag1_rd_d;
            tag1_id_q     <= tag1_id_d;
            tag2_rd_q     <= tag1_rd_q;
            tag2_id_q     <= tag1_id_q;
            a_rsp_valid_q <= tag2_rd_q && !tag2_id_q;
            b_rsp_valid_q <= tag2_rd_q && tag2_id_q;
            if (tag2_rd_q && !tag2_id_q) begin
                a_rsp_data_q <= mem_rdata;
            end
            if (tag2_rd_q && tag2_id_q) begin
                b_rsp_data_q <= mem_rdata;
            end
        end
    end

    assign clear_done  = clear_done_q;
    assign a_ready     = grant_a;
    assign b_ready     = grant_b;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_data  = a_rsp_data_q;
    assign b_rsp_data  = b_rsp_data_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic, checked each cycle against a
// transaction-level model (shadow memory, response queue with due cycles, round-robin preference).
module tb_bram_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_req = 1'b0;
    logic          clear_done;
    logic          a_valid = 1'b0, a_wr = 1'b0, b_valid = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_data, b_rsp_data;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    bram_arbiter #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clear_done(clear_done),
        .a_valid(a_valid), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        bit            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_serve, m_done, m_last_b, m_ga, m_gb, m_av, m_bv, m_mwr;
    int            m_left, edge_n;
    logic [AW-1:0] m_maddr;
    logic [DW-1:0] m_mwdata, m_adata, m_bdata;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_serve = 0; m_done = 0; m_last_b = 1; m_ga = 0; m_gb = 0;
        m_av = 0; m_bv = 0; m_mwr = 0; m_maddr = '0; m_mwdata = '0;
        m_adata = '0; m_bdata = '0; m_left = DEPTH;
    endtask

    task automatic exp_grant(output bit ga, output bit gb);
        bit ok;
        ok = m_serve && m_done && !clr_req && !rst;
        ga = ok && a_valid && (!b_valid || m_last_b);
        gb = ok && b_valid && (!a_valid || !m_last_b);
    endtask

    task automatic issue(input bit id, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        rsp_t r;
        m_mwr = wr; m_maddr = addr; m_mwdata = data;
        if (wr) begin
            m_mem[addr] = data;
        end else begin
            r.id = id; r.data = m_mem[addr]; r.due = edge_n + 2;
            q.push_back(r);
        end
    endtask

    task automatic model_edge();
        bit ga, gb, old_serve;
        if (rst) begin
            model_reset();
            return;
        end
        exp_grant(ga, gb);
        edge_n++;
        old_serve = m_serve;
        m_mwr = 0;
        if (!m_serve) begin
            m_mwr = 1; m_maddr = AW'(DEPTH - m_left); m_mwdata = '0;
            m_left--;
            if (m_left == 0) m_serve = 1;
        end else if (clr_req) begin
            m_serve = 0; m_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (ga) begin
            issue(0, a_wr, a_addr, a_wdata);
            m_last_b = 0;
        end else if (gb) begin
            issue(1, b_wr, b_addr, b_wdata);
            m_last_b = 1;
        end
        m_done = old_serve;
        m_ga = ga; m_gb = gb;
        m_av = 0; m_bv = 0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            if (q[0].id) begin m_bv = 1; m_bdata = q[0].data; end
            else begin m_av = 1; m_adata = q[0].data; end
            void'(q.pop_front());
        end
    endtask

    task automatic check_outputs();
        bit ga, gb;
        if (rst) model_reset();
        exp_grant(ga, gb);
        chk("a_ready", 32'(a_ready), 32'(ga));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("clear_done", 32'(clear_done), 32'(m_done));
        chk("mem_wr", 32'(mem_wr), 32'(m_mwr));
        chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
        chk("mem_wdata", mem_wdata, m_mwdata);
        chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_av));
        chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_bv));
        chk("a_rsp_data", a_rsp_data, m_adata);
        chk("b_rsp_data", b_rsp_data, m_bdata);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_a(input bit v, input bit wr, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d);
        a_valid = v; a_wr = wr; a_addr = ad; a_wdata = d;
    endtask

    task automatic drive_b(input bit v, input bit wr, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d);
        b_valid = v; b_wr = wr; b_addr = ad; b_wdata = d;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40 && !clear_done; n++) cycle();
        chk("clear_done_reached", 32'(clear_done), 32'd1);
    endtask

    initial begin
        int n, nwr, nlow;
        edge_n = 0;
        model_reset();

        // Reset, then the zero-fill sequence.
        repeat (3) cycle();
        rst = 0;
        n = 0; nwr = 0;
        while (!clear_done && n < 40) begin
            cycle();
            n++;
            if (mem_wr) nwr++;
        end
        chk("clear_latency", 32'(n), 32'd17);
        chk("clear_writes", 32'(nwr), 32'd16);

        // A write then read at the same address.
        drive_a(1, 1, 4'd3, 32'hDEADBEEF); cycle();
        drive_a(1, 0, 4'd3, 32'h0);        cycle();
        drive_a(0, 0, 4'd0, 32'h0);
        repeat (4) cycle();
        chk("a_rd_deadbeef", a_rsp_data, 32'hDEADBEEF);

        // Both requesters read concurrently; B wrote last so A wins first.
        drive_a(1, 1, 4'd1, 32'hAAAA0001); cycle();
        drive_a(0, 0, 4'd0, 32'h0);
        drive_b(1, 1, 4'd2, 32'hBBBB0002); cycle();
        drive_a(1, 0, 4'd1, 32'h0);
        drive_b(1, 0, 4'd2, 32'h0);
        repeat (4) cycle();
        drive_a(0, 0, 4'd0, 32'h0);
        drive_b(0, 0, 4'd0, 32'h0);
        repeat (4) cycle();
        chk("ab_rd_a", a_rsp_data, 32'hAAAA0001);
        chk("ab_rd_b", b_rsp_data, 32'hBBBB0002);

        // Write, clear, read back zero.
        drive_b(1, 1, 4'd5, 32'h12345678); cycle();
        drive_b(0, 0, 4'd0, 32'h0);
        clr_req = 1; cycle();
        clr_req = 0;
        nlow = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (!clear_done) nlow++;
            else if (nlow > 0) break;
        end
        chk("clr_low_cycles", 32'(nlow), 32'd16);
        drive_a(1, 0, 4'd5, 32'h0); cycle();
        drive_a(0, 0, 4'd0, 32'h0);
        repeat (4) cycle();
        chk("rd_after_clear", a_rsp_data, 32'h0);

        // Read in flight across a clear request still returns pre-clear data.
        drive_a(1, 1, 4'd7, 32'hCAFE0001); cycle();
        drive_a(1, 0, 4'd7, 32'h0);        cycle();
        drive_a(0, 0, 4'd0, 32'h0);
        clr_req = 1; cycle();
        clr_req = 0;
        repeat (3) cycle();
        chk("rd_across_clr", a_rsp_data, 32'hCAFE0001);
        wait_done();

        // Read in flight killed by reset: no response.
        drive_b(1, 0, 4'd2, 32'h0); cycle();
        drive_b(0, 0, 4'd0, 32'h0);
        rst = 1; cycle();
        rst = 0;
        repeat (3) cycle();
        chk("rst_no_rsp", 32'(b_rsp_valid), 32'd0);
        wait_done();

        // Random traffic, holding each request until accepted.
        for (int c = 0; c < 600; c++) begin
            if (!a_valid || m_ga)
                drive_a($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 7)), $urandom);
            if (!b_valid || m_gb)
                drive_b($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 7)), $urandom);
            clr_req = ($urandom_range(0, 79) == 0);
            cycle();
        end
        clr_req = 0;
        drive_a(0, 0, 4'd0, 32'h0);
        drive_b(0, 0, 4'd0, 32'h0);
        repeat (6) cycle();
        chk("rsp_queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Sequencer and two-requester arbiter in front of a single-port block RAM (1 port: wr, addr, input_data, output_data; synchronous write; registered read returned the cycle after a read is presented).
- After reset or on command, it zero-fills every RAM word. It then shares the RAM port between requester A and requester B with round-robin arbitration and a valid/ready request handshake.
- It returns read data to the requester that issued the read.

Parameters:
- RAM_DATA_WIDTH, 32, RAM word width.
- RAM_ADDR_WIDTH, 4, RAM address width; DEPTH = 2**RAM_ADDR_WIDTH.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr_req  in  1  single-cycle pulse: re-run zero-fill
- clear_done  out  1  high when zero-fill is complete and the block is serving requests
- a_valid, b_valid  in  1  request present
- a_wr, b_wr  in  1  1=write, 0=read
- a_addr, b_addr  in  RAM_ADDR_WIDTH  request address
- a_wdata, b_wdata  in  RAM_DATA_WIDTH  write data
- a_ready, b_ready  out  1  request accepted this cycle
- a_rsp_valid, b_rsp_valid  out  1  one-cycle read-response pulse
- a_rsp_data, b_rsp_data  out  RAM_DATA_WIDTH  read data, held until the next response
- mem_wr  out  1  to RAM wr
- mem_addr  out  RAM_ADDR_WIDTH  to RAM addr
- mem_wdata  out  RAM_DATA_WIDTH  to RAM input_data
- mem_rdata  in  RAM_DATA_WIDTH  from RAM output_data

Behaviour:
- Reset
  - clk is the only clock; rst is asynchronous and active-high.
  - rst forces all outputs to 0 and sets FSM to CLEAR, clear counter to 0 and rr_last to B (so A wins the first tie).
  - In-flight reads are discarded; no response is produced for them.
- FSM states
  - CLEAR:
    - Each cycle registers mem_wr=1, mem_addr=cnt, mem_wdata=0, then cnt++.
    - After the cycle that issues cnt=DEPTH-1, go to SERVE and reset cnt to 0.
    - a_ready=b_ready=0 throughout.
  - SERVE: arbitration active.
    - clr_req=1 blocks grants that cycle; next state CLEAR.
    - clr_req while already in CLEAR is ignored (no restart).
- clear_done
  - Registered: equals (state==SERVE).
  - First rises DEPTH+1 cycles after rst deasserts, i.e. 17 cycles for the defaults.
  - Falls the cycle after clr_req is sampled.
- Arbitration (SERVE, clr_req=0)
  - Only one valid: grant it.
  - Both valid: grant the requester other than rr_last.
  - rr_last updates only on a grant.
  - x_ready = grant_x. It is combinational from valid, state and rr_last, and never high without x_valid.
- Handshake
  - A request transfers when x_valid & x_ready.
  - Requester holds wr/addr/wdata stable while valid & !ready.
  - Throughput is 1 request per cycle in total.
- Pipeline (request accepted in cycle N)
  - N+1: mem_wr/mem_addr/mem_wdata are registered copies of the granted request.
  - No grant in N: mem_wr=0, mem_addr/mem_wdata hold their previous values.
  - Read: RAM output valid in N+2; captured into x_rsp_data with x_rsp_valid=1 during N+3. Fixed latency of 3 cycles.
  - Write: no response. The RAM holds the new data from end of N+1.
  - Back-to-back write then read to the same address returns the new data.
- Response tagging: a 2-stage shift register carries {is_read, requester_id} alongside the memory stage, so responses arrive in grant order.
- clr_req with reads in flight: reads already granted complete normally and return correct pre-clear data. Clear writes begin the cycle after clr_req, on the mem stage.
- Address wrap: the clear counter is RAM_ADDR_WIDTH+1 bits wide, so there is no wrap at DEPTH-1.

Test Plan:
- Reset release -> mem_wr=1 for exactly 16 consecutive cycles, addr 0..15, wdata=0. clear_done rises on the 17th cycle. ready stays 0 until then.
- A writes 0xDEADBEEF @3; A reads @3 on the next cycle -> a_rsp_valid one-cycle pulse 3 cycles after read accept, a_rsp_data=0xDEADBEEF. b_rsp_valid stays 0.
- A and B both hold valid reads (@1, @2) for 4 cycles -> grants A,B,A,B. Responses alternate in the same order, 3 cycles after each grant.
- B writes 0x12345678 @5, then clr_req pulse, then A reads @5 after clear_done -> 0x00000000. clear_done low for 16 cycles.
- A read @7 (holding 0xCAFE0001) accepted, clr_req the next cycle -> a_rsp_data=0xCAFE0001 still delivered, then clear proceeds.
- Read accepted, rst asserted the next cycle for 1 cycle -> no rsp_valid ever issued for it. All outputs 0 during rst. Clear restarts at addr 0.
